// File: rtl/fifo_rd_unpack_checker.sv
// Read-side consumer of a 16b->32b asymmetric FIFO: credit-limited reads, word buffer, 2:1 unpack.
// Optional incrementing-sequence checker is compiled in when SEQ_CHECK_EN is defined.
module fifo_rd_unpack_checker #(
  parameter int unsigned BUF_DEPTH = 4,
  parameter bit          SEED_LOCK = 1'b1,
  parameter logic [15:0] EXP_SEED  = 16'h0001
) (
  input  logic        rd_clk_i,
  input  logic        a_rst_i,
  input  logic        rst_busy_i,
  input  logic        start_i,
  input  logic        hold_i,
  input  logic        empty_i,
  output logic        rd_en_o,
  input  logic [31:0] rdata_i,
  input  logic        rd_valid_i,
  output logic [15:0] out_data_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        err_o,
  output logic [15:0] err_cnt_o,
  output logic        ovf_o,
  output logic [31:0] word_cnt_o,
  output logic [1:0]  state_o
);

  localparam int unsigned AW = $clog2(BUF_DEPTH);

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_ARM   = 2'd1,
    ST_RUN   = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [31:0]   mem [BUF_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_n;
  logic [AW:0]   count, count_n, remain, inflight, inflight_n;
  logic          half, half_n;
  logic          clear, xfer, pop, push, full, ovf_evt, credit_ok;
  logic [31:0]   head_n;

  assign state_o = state;

  always_comb begin
    state_n = state;
    if (rst_busy_i) begin
      state_n = ST_WAIT;
    end else begin
      case (state)
        ST_WAIT:  state_n = ST_ARM;
        ST_ARM:   if (start_i) state_n = ST_RUN;
        ST_RUN:   if (hold_i) state_n = ST_PAUSE;
        ST_PAUSE: if (!hold_i) state_n = ST_RUN;
        default:  state_n = ST_WAIT;
      endcase
    end
  end

  // Output stage is a register fed from next-state buffer values; an empty buffer bypasses rdata_i.
  always_comb begin
    clear      = rst_busy_i;
    xfer       = out_valid_o & out_ready_i;
    pop        = xfer & half;
    full       = (count == (AW+1)'(BUF_DEPTH));
    push       = rd_valid_i & (~full | pop);
    ovf_evt    = rd_valid_i & full & ~pop & ~clear;
    count_n    = count + (AW+1)'(push) - (AW+1)'(pop);
    remain     = count - (AW+1)'(pop);
    rd_ptr_n   = rd_ptr + AW'(pop);
    half_n     = xfer ? ~half : half;
    head_n     = (remain == '0) ? rdata_i : mem[rd_ptr_n];
    inflight_n = inflight + (AW+1)'(rd_en_o) - (AW+1)'(rd_valid_i && (inflight != '0));
    credit_ok  = ({1'b0, count_n} + {1'b0, inflight_n}) < (AW+2)'(BUF_DEPTH);
  end

  always_ff @(posedge rd_clk_i) begin
    if (push && !clear) mem[wr_ptr] <= rdata_i;
  end

  always_ff @(posedge rd_clk_i or posedge a_rst_i) begin
    if (a_rst_i) begin
      state       <= ST_WAIT;
      rd_en_o     <= 1'b0;
      word_cnt_o  <= '0;
      ovf_o       <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      inflight    <= '0;
      half        <= 1'b0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
    end else begin
      state      <= state_n;
      rd_en_o    <= (state_n == ST_RUN) & ~empty_i & credit_ok;
      word_cnt_o <= word_cnt_o + {31'b0, rd_valid_i};
      if (ovf_evt) ovf_o <= 1'b1;
      if (clear) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        count       <= '0;
        inflight    <= '0;
        half        <= 1'b0;
        out_valid_o <= 1'b0;
        out_data_o  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        rd_ptr      <= rd_ptr_n;
        count       <= count_n;
        inflight    <= inflight_n;
        half        <= half_n;
        out_valid_o <= (count_n != '0);
        out_data_o  <= half_n ? head_n[15:0] : head_n[31:16];
      end
    end
  end

`ifdef SEQ_CHECK_EN
  logic [15:0] exp_val, cmp_val;
  logic        seeded;

  // The first sample after WAIT either seeds itself or is compared to EXP_SEED.
  assign cmp_val = seeded ? exp_val : (SEED_LOCK ? out_data_o : EXP_SEED);

  always_ff @(posedge rd_clk_i or posedge a_rst_i) begin
    if (a_rst_i) begin
      exp_val   <= '0;
      seeded    <= 1'b0;
      err_o     <= 1'b0;
      err_cnt_o <= '0;
    end else if (rst_busy_i) begin
      exp_val <= '0;
      seeded  <= 1'b0;
    end else if (xfer) begin
      seeded  <= 1'b1;
      exp_val <= out_data_o + 16'd1;
      if (out_data_o != cmp_val) begin
        err_o <= 1'b1;
        if (err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 16'd1;
      end
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{SEED_LOCK, EXP_SEED};
  assign err_o      = 1'b0;
  assign err_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_unpack_checker.sv
// Directed bench for fifo_rd_unpack_checker with a latency-modelled FIFO read port.
module tb_fifo_rd_unpack_checker;
  localparam int BUF_DEPTH = 4;
  localparam int LAT       = 3;
`ifdef SEQ_CHECK_EN
  localparam logic [31:0] ERR_AFTER = 32'd1;
`else
  localparam logic [31:0] ERR_AFTER = 32'd0;
`endif

  logic        rd_clk, a_rst_i, rst_busy_i, start_i, hold_i, empty_i, rd_en_o;
  logic [31:0] rdata_i;
  logic        rd_valid_i;
  logic [15:0] out_data_o;
  logic        out_valid_o, out_ready_i, err_o, ovf_o;
  logic [15:0] err_cnt_o;
  logic [31:0] word_cnt_o;
  logic [1:0]  state_o;

  fifo_rd_unpack_checker #(.BUF_DEPTH(BUF_DEPTH)) dut (
    .rd_clk_i(rd_clk), .a_rst_i(a_rst_i), .rst_busy_i(rst_busy_i), .start_i(start_i),
    .hold_i(hold_i), .empty_i(empty_i), .rd_en_o(rd_en_o), .rdata_i(rdata_i),
    .rd_valid_i(rd_valid_i), .out_data_o(out_data_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .err_o(err_o), .err_cnt_o(err_cnt_o), .ovf_o(ovf_o),
    .word_cnt_o(word_cnt_o), .state_o(state_o)
  );

  initial begin
    rd_clk = 1'b0;
    forever #5 rd_clk = ~rd_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       busy;
    logic       start;
    logic       hold;
    logic [1:0] exp_state;
    logic       exp_rd_en;
  } vec_t;

  vec_t        tbl [14];
  logic [15:0] exp_q[$];
  logic [31:0] fifo_q[$];
  logic        slot_v [16];
  logic [31:0] slot_d [16];
  int          cyc, rd_en_cnt, n_checks, n_fail, base;
  logic        inj, prev_stall;
  logic [31:0] inj_data;
  logic [15:0] prev_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic fifo_push(input logic [31:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w[31:16]);
    exp_q.push_back(w[15:0]);
    empty_i = 1'b0;
  endtask

  // Ends the current cycle: scores any transfer, advances one clock, then plays the FIFO read port.
  task automatic tick();
    logic [15:0] exp_s;
    int slot;
    if (out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_sample: got %0h, want none", out_data_o);
      end else begin
        exp_s = exp_q.pop_front();
        check("sample", 32'(out_data_o), 32'(exp_s));
      end
    end
    prev_stall = out_valid_o && !out_ready_i;
    prev_data  = out_data_o;
    @(posedge rd_clk);
    #1;
    if (prev_stall) begin
      check("held_valid", 32'(out_valid_o), 32'd1);
      check("held_data", 32'(out_data_o), 32'(prev_data));
    end
    cyc++;
    if (rd_en_o) rd_en_cnt++;
    if (rd_en_o && fifo_q.size() > 0) begin
      slot = (cyc + LAT) % 16;
      slot_v[slot] = 1'b1;
      slot_d[slot] = fifo_q.pop_front();
    end
    slot = cyc % 16;
    if (inj) begin
      rd_valid_i = 1'b1;
      rdata_i    = inj_data;
      inj        = 1'b0;
    end else if (slot_v[slot]) begin
      rd_valid_i = 1'b1;
      rdata_i    = slot_d[slot];
    end else begin
      rd_valid_i = 1'b0;
    end
    slot_v[slot] = 1'b0;
    empty_i = (fifo_q.size() == 0);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    repeat (3) tick();
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_state"}, 32'(state_o), 32'd0);
    check({name, "_rd_en"}, 32'(rd_en_o), 32'd0);
    check({name, "_out_valid"}, 32'(out_valid_o), 32'd0);
    check({name, "_out_data"}, 32'(out_data_o), 32'd0);
    check({name, "_err"}, 32'(err_o), 32'd0);
    check({name, "_err_cnt"}, 32'(err_cnt_o), 32'd0);
    check({name, "_ovf"}, 32'(ovf_o), 32'd0);
    check({name, "_word_cnt"}, word_cnt_o, 32'd0);
  endtask

  initial begin
    a_rst_i = 1'b1; rst_busy_i = 1'b1; start_i = 1'b0; hold_i = 1'b0;
    empty_i = 1'b1; rd_valid_i = 1'b0; rdata_i = '0; out_ready_i = 1'b1;
    inj = 1'b0; inj_data = '0; prev_stall = 1'b0; prev_data = '0;
    cyc = 0; rd_en_cnt = 0; n_checks = 0; n_fail = 0; base = 0;
    for (int i = 0; i < 16; i++) begin
      slot_v[i] = 1'b0;
      slot_d[i] = '0;
    end

    //            busy  start hold  state  rd_en
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 2'd1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 2'd2, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 2'd3, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 2'd2, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 2'd1, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 2'd2, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 2'd2, 1'b0};

    tick();
    tick();
    check_all_zero("reset");
    a_rst_i = 1'b0;

    for (int i = 0; i < 14; i++) begin
      rst_busy_i = tbl[i].busy;
      start_i    = tbl[i].start;
      hold_i     = tbl[i].hold;
      tick();
      check($sformatf("fsm_state_%0d", i), 32'(state_o), 32'(tbl[i].exp_state));
      check($sformatf("fsm_rd_en_%0d", i), 32'(rd_en_o), 32'(tbl[i].exp_rd_en));
    end
    start_i = 1'b1;

    // Basic stream with read latency 3.
    fifo_push(32'h0001_0002);
    fifo_push(32'h0003_0004);
    tick();
    check("rd_en_on_data", 32'(rd_en_o), 32'd1);
    repeat (3) tick();
    check("out_valid_before_data", 32'(out_valid_o), 32'd0);
    tick();
    check("out_valid_latency", 32'(out_valid_o), 32'd1);
    check("first_sample", 32'(out_data_o), 32'h0001);
    drain("seq_a");
    check("err_cnt_a", 32'(err_cnt_o), 32'd0);
    check("err_a", 32'(err_o), 32'd0);
    check("word_cnt_a", word_cnt_o, 32'd2);

    // 5 follows 4, then 7 skips 6.
    fifo_push(32'h0005_0007);
    drain("seq_err");
    check("err_cnt_skip", 32'(err_cnt_o), ERR_AFTER);
    check("err_skip", 32'(err_o), ERR_AFTER);
    check("word_cnt_err", word_cnt_o, 32'd3);

    // Re-enter WAIT, re-arm, then stream across the 16b wrap.
    rst_busy_i = 1'b1;
    tick();
    check("busy_state", 32'(state_o), 32'd0);
    rst_busy_i = 1'b0;
    tick();
    check("rearm_state", 32'(state_o), 32'd1);
    tick();
    check("rerun_state", 32'(state_o), 32'd2);
    fifo_push(32'hFFFE_FFFF);
    fifo_push(32'h0000_0001);
    drain("seq_wrap");
    check("err_cnt_wrap", 32'(err_cnt_o), ERR_AFTER);
    check("word_cnt_wrap", word_cnt_o, 32'd5);

    // Downstream stalled for 20 cycles: credits cap outstanding words at BUF_DEPTH.
    out_ready_i = 1'b0;
    base = rd_en_cnt;
    for (int i = 0; i < 6; i++) fifo_push({16'(2 + 2 * i), 16'(3 + 2 * i)});
    repeat (20) tick();
    check("credit_limit", 32'(rd_en_cnt - base), 32'(BUF_DEPTH));
    check("stall_no_ovf", 32'(ovf_o), 32'd0);
    check("stall_valid", 32'(out_valid_o), 32'd1);
    check("stall_data", 32'(out_data_o), 32'h0002);
    out_ready_i = 1'b1;
    drain("seq_stall");
    check("err_cnt_stall", 32'(err_cnt_o), ERR_AFTER);
    check("word_cnt_stall", word_cnt_o, 32'd11);

    // Pause with two reads in flight.
    base = rd_en_cnt;
    for (int i = 0; i < 4; i++) fifo_push({16'(14 + 2 * i), 16'(15 + 2 * i)});
    for (int i = 0; i < 10 && (rd_en_cnt - base) < 2; i++) tick();
    hold_i = 1'b1;
    repeat (10) tick();
    check("pause_state", 32'(state_o), 32'd3);
    check("pause_reads", 32'(rd_en_cnt - base), 32'd2);
    check("pause_inflight_done", 32'(exp_q.size()), 32'd4);
    hold_i = 1'b0;
    drain("seq_pause");
    check("resume_reads", 32'(rd_en_cnt - base), 32'd4);
    check("word_cnt_pause", word_cnt_o, 32'd15);

    // Fill the buffer, then force an unsolicited word.
    out_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) fifo_push({16'(22 + 2 * i), 16'(23 + 2 * i)});
    repeat (12) tick();
    check("full_no_ovf", 32'(ovf_o), 32'd0);
    inj_data = 32'hDEAD_BEEF;
    inj = 1'b1;
    tick();
    tick();
    check("ovf_set", 32'(ovf_o), 32'd1);
    check("word_cnt_ovf", word_cnt_o, 32'd20);
    check("ovf_head", 32'(out_data_o), 32'h0016);
    out_ready_i = 1'b1;
    drain("seq_ovf");
    check("ovf_sticky", 32'(ovf_o), 32'd1);
    check("ovf_no_extra", 32'(out_valid_o), 32'd0);
    check("err_cnt_ovf", 32'(err_cnt_o), ERR_AFTER);

    // Asynchronous reset mid-stream.
    fifo_push(32'h001E_001F);
    fifo_push(32'h0020_0021);
    repeat (6) tick();
    a_rst_i = 1'b1;
    fifo_q.delete();
    exp_q.delete();
    for (int i = 0; i < 16; i++) slot_v[i] = 1'b0;
    rd_valid_i = 1'b0;
    empty_i = 1'b1;
    #1;
    check_all_zero("midrst");
    tick();
    check_all_zero("midrst_hold");
    a_rst_i = 1'b0;
    tick();
    check("after_rst_state", 32'(state_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
